// File: rtl/platform_rom_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 4096x32 platform memory.
// Zero-wait command acceptance, one-cycle read response tagged to the issuing master.
module platform_rom_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_debugaccess,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_debugaccess,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    input  logic              freeze,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [CNT_W-1:0]  contention_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
        logic              debugaccess;
    } cmd_t;

    cmd_t m0_cmd, m1_cmd, sel_cmd;
    logic req0, req1;
    logic grant0, grant1;
    logic rd_grant;
    logic last_grant;
    logic rsp_pending;
    logic rsp_id;

    assign m0_cmd = '{m0_address, m0_read, m0_write, m0_writedata, m0_byteenable, m0_debugaccess};
    assign m1_cmd = '{m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_debugaccess};

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Reset gates grants combinationally so nothing reaches memory while held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!freeze && reset_n) begin
            if (req0 && req1) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    always_comb begin
        sel_cmd = '0;
        if (grant0)
            sel_cmd = m0_cmd;
        else if (grant1)
            sel_cmd = m1_cmd;
    end

    // A write wins over a simultaneous read from the same master: no response.
    assign rd_grant = sel_cmd.read & ~sel_cmd.write;

    assign m0_waitrequest  = ~grant0;
    assign m1_waitrequest  = ~grant1;

    assign mem_chipselect  = grant0 | grant1;
    assign mem_address     = sel_cmd.address;
    assign mem_byteenable  = sel_cmd.byteenable;
    assign mem_writedata   = sel_cmd.writedata;
    assign mem_write       = sel_cmd.write & sel_cmd.debugaccess;
    assign mem_debugaccess = sel_cmd.debugaccess;
    assign mem_clken       = ~freeze | rsp_pending;

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rsp_pending & ~rsp_id;
    assign m1_readdatavalid = rsp_pending & rsp_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_pending    <= 1'b0;
            rsp_id         <= 1'b0;
            last_grant     <= 1'b1;
            contention_cnt <= '0;
        end else begin
            rsp_pending <= rd_grant;
            rsp_id      <= grant1;
            if (grant0 | grant1)
                last_grant <= grant1;
            if (req0 && req1 && !freeze && contention_cnt != {CNT_W{1'b1}})
                contention_cnt <= contention_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_platform_rom_arbiter.sv
// Directed bench for platform_rom_arbiter: behavioural memory plus a read-response scoreboard.
module tb_platform_rom_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_debugaccess, m1_debugaccess;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              freeze;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_chipselect, mem_write, mem_debugaccess, mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [CNT_W-1:0]  contention_cnt;

    int total = 0;
    int bad   = 0;
    logic [DATA_W:0] exp_q[$];

    always #5 clk = ~clk;

    platform_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_debugaccess(m0_debugaccess), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_debugaccess(m1_debugaccess), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .freeze(freeze),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_debugaccess(mem_debugaccess),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .contention_cnt(contention_cnt)
    );

    // Behavioural single-port RAM; every word starts as 0xC0DE0000 | address.
    logic [DATA_W-1:0] mem [0:4095];
    bit mem_init;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'hC0DE_0000 | i;
            mem_init <= 1'b1;
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write)
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            mem_readdata <= mem[mem_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops one expected {id,data} per readdatavalid strobe.
    always @(negedge clk) begin
        if (m0_readdatavalid || m1_readdatavalid) begin
            logic [DATA_W:0] e;
            total++;
            if (m0_readdatavalid && m1_readdatavalid) begin
                bad++;
                $display("FAIL rsp_both_valid: got both strobes expected one");
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got valid m0=%b m1=%b expected none",
                         m0_readdatavalid, m1_readdatavalid);
            end else begin
                e = exp_q.pop_front();
                if (m1_readdatavalid !== e[DATA_W] ||
                    (m1_readdatavalid ? m1_readdata : m0_readdata) !== e[DATA_W-1:0]) begin
                    bad++;
                    $display("FAIL rsp_data: got id=%0d data=%h expected id=%0d data=%h",
                             m1_readdatavalid, m1_readdatavalid ? m1_readdata : m0_readdata,
                             e[DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
        m0_byteenable = '1; m0_debugaccess = 0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
        m1_byteenable = '1; m1_debugaccess = 0;
    endtask

    task automatic push(input logic id, input logic [31:0] d);
        exp_q.push_back({id, d});
    endtask

    // Both masters read back-to-back; each advances its address only when accepted.
    task automatic contend(input int n, input int first);
        int i0 = 0;
        int i1 = 0;
        for (int k = 0; k < n; k++) begin
            int g = (first + k) % 2;
            idle_in();
            m0_read = 1; m0_address = 12'(i0);
            m1_read = 1; m1_address = 12'(12'h800 + i1);
            #2;
            chk("contend_wait0", 32'(m0_waitrequest), 32'(g == 1));
            chk("contend_wait1", 32'(m1_waitrequest), 32'(g == 0));
            if (g == 0) begin push(0, 32'hC0DE_0000 | i0); i0++; end
            else        begin push(1, 32'hC0DE_0800 | i1); i1++; end
            step();
        end
        idle_in();
    endtask

    initial begin
        reset_n = 0; freeze = 0;
        idle_in();
        step(); step();
        // reset state, with a request present
        m0_read = 1;
        #2;
        chk("rst_wait0", 32'(m0_waitrequest), 1);
        chk("rst_wait1", 32'(m1_waitrequest), 1);
        chk("rst_cs", 32'(mem_chipselect), 0);
        chk("rst_cnt", 32'(contention_cnt), 0);
        step();
        idle_in();
        reset_n = 1;
        #2;
        chk("idle_wait0", 32'(m0_waitrequest), 1);
        chk("idle_wait1", 32'(m1_waitrequest), 1);
        chk("idle_cs", 32'(mem_chipselect), 0);
        step();

        // contention, m0 first
        contend(8, 0);
        #2;
        chk("cnt_after8", 32'(contention_cnt), 8);
        step();

        // single m0 read
        m0_read = 1; m0_address = 12'h010;
        #2;
        chk("single_wait0", 32'(m0_waitrequest), 0);
        chk("single_addr", 32'(mem_address), 32'h010);
        push(0, 32'hC0DE_0010);
        step(); idle_in(); step();

        // debug write, readback
        m1_write = 1; m1_debugaccess = 1; m1_address = 12'h020; m1_writedata = 32'hDEADBEEF;
        #2;
        chk("wr_wait1", 32'(m1_waitrequest), 0);
        chk("wr_memwrite", 32'(mem_write), 1);
        chk("wr_wdata", mem_writedata, 32'hDEADBEEF);
        step(); idle_in();
        m1_read = 1; m1_address = 12'h020; push(1, 32'hDEADBEEF);
        step(); idle_in();
        // non-debug write is accepted and dropped
        m1_write = 1; m1_debugaccess = 0; m1_address = 12'h020; m1_writedata = 32'h12345678;
        #2;
        chk("nodbg_wait1", 32'(m1_waitrequest), 0);
        chk("nodbg_memwrite", 32'(mem_write), 0);
        chk("nodbg_cs", 32'(mem_chipselect), 1);
        step(); idle_in();
        m0_read = 1; m0_address = 12'h020; push(0, 32'hDEADBEEF);
        step(); idle_in();
        // read+write together: write wins, no response
        m0_read = 1; m0_write = 1; m0_debugaccess = 1; m0_address = 12'h030;
        m0_writedata = 32'h55AA55AA;
        #2;
        chk("rw_memwrite", 32'(mem_write), 1);
        step(); idle_in(); step();
        // partial byte write
        m1_write = 1; m1_debugaccess = 1; m1_address = 12'h020;
        m1_writedata = 32'h0000CAFE; m1_byteenable = 4'b0011;
        step(); idle_in();
        m0_read = 1; m0_address = 12'h030; push(0, 32'h55AA55AA);
        step(); idle_in();
        m1_read = 1; m1_address = 12'h020; push(1, 32'hDEADCAFE);
        step(); idle_in(); step();

        // freeze under contention; last grant was m1, so m0 wins first
        m0_read = 1; m0_address = 12'h100; m1_read = 1; m1_address = 12'h900;
        #2;
        chk("frz_pre_wait0", 32'(m0_waitrequest), 0);
        push(0, 32'hC0DE_0100);
        step();
        m0_address = 12'h101; freeze = 1;
        #2;
        chk("frz_wait0", 32'(m0_waitrequest), 1);
        chk("frz_wait1", 32'(m1_waitrequest), 1);
        chk("frz_cs", 32'(mem_chipselect), 0);
        chk("frz_clken_pend", 32'(mem_clken), 1);
        step();
        #2;
        chk("frz_clken", 32'(mem_clken), 0);
        chk("frz_cnt", 32'(contention_cnt), 9);
        step(); step();
        freeze = 0;
        #2;
        chk("unfrz_wait1", 32'(m1_waitrequest), 0);
        chk("unfrz_wait0", 32'(m0_waitrequest), 1);
        push(1, 32'hC0DE_0900);
        step();
        m1_address = 12'h901;
        #2;
        chk("unfrz2_wait0", 32'(m0_waitrequest), 0);
        push(0, 32'hC0DE_0101);
        step();
        // reset in the cycle after an m1 read grant
        m0_address = 12'h102; m1_address = 12'h901;
        #2;
        chk("cnt_after_frz", 32'(contention_cnt), 11);
        chk("pre_rst_wait1", 32'(m1_waitrequest), 0);
        step();
        reset_n = 0;
        #2;
        chk("rst_rdv0", 32'(m0_readdatavalid), 0);
        chk("rst_rdv1", 32'(m1_readdatavalid), 0);
        chk("rst2_wait1", 32'(m1_waitrequest), 1);
        chk("rst2_cnt", 32'(contention_cnt), 0);
        step(); step();
        reset_n = 1;
        // after release m0 wins the first tie; counter saturates at 15
        contend(18, 0);
        #2;
        chk("cnt_saturated", 32'(contention_cnt), 15);
        step(); step(); step();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
